// File: rtl/control_unit.sv
// control_unit: hard-wired multi-cycle sequencer for the cpu datapath.
// Fetch (F0..F2) then up to three execute cycles (E0..E2) per instruction,
// with a ready-based memory handshake in F1, ld E1 and st E2.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir_out,
  input  logic        mem_ready,
  output logic        ir_en,
  output logic        pc_increment,
  output logic        pc_in_alu,
  output logic        pc_in_rf_a,
  output logic        ma_in_pc,
  output logic        ma_in_alu,
  output logic        md_in_memory,
  output logic        md_in_rf_b,
  output logic        alu_a_in_rf,
  output logic        alu_a_in_pc,
  output logic        alu_b_in_rf,
  output logic        alu_b_in_constant,
  output logic        lo_en,
  output logic        hi_en,
  output logic        rf_in_alu,
  output logic        rf_in_hi,
  output logic        rf_in_lo,
  output logic        rf_in_md,
  output logic [3:0]  rf_a_addr,
  output logic [3:0]  rf_b_addr,
  output logic [3:0]  rf_z_addr,
  output logic [11:0] alu_select,
  output logic [31:0] constant_c,
  output logic        mem_read,
  output logic        mem_write,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_RESET, S_F0, S_F1, S_F2, S_E0, S_E1, S_E2, S_HALT
  } state_t;

  localparam logic [4:0] OP_ADDI = 5'h08, OP_ANDI = 5'h09, OP_ORI  = 5'h0A,
                         OP_LD   = 5'h0B, OP_ST   = 5'h0C, OP_MUL  = 5'h0D,
                         OP_DIV  = 5'h0E, OP_NEG  = 5'h0F, OP_NOT  = 5'h10,
                         OP_MFHI = 5'h11, OP_MFLO = 5'h12, OP_JR   = 5'h13,
                         OP_JAL  = 5'h14, OP_BR   = 5'h15, OP_HALT = 5'h17;

  // One-hot ALU codes, add in bit 11 down to not in bit 0
  localparam logic [11:0] ALU_ADD = 12'h800, ALU_AND = 12'h020, ALU_OR  = 12'h010,
                          ALU_MUL = 12'h008, ALU_DIV = 12'h004, ALU_NEG = 12'h002,
                          ALU_NOT = 12'h001;

  state_t      state, state_nx;
  logic        illegal_q;
  logic [4:0]  op;
  logic [3:0]  ra, rb, rc;
  logic [31:0] c_ext;

  assign op    = ir_out[31:27];
  assign ra    = ir_out[26:23];
  assign rb    = ir_out[22:19];
  assign rc    = ir_out[18:15];
  assign c_ext = {{13{ir_out[18]}}, ir_out[18:0]};

  // Next-state selection; mem_ready only matters in the three wait states
  always_comb begin
    state_nx = S_F0;
    case (state)
      S_RESET: state_nx = S_F0;
      S_F0:    state_nx = S_F1;
      S_F1:    state_nx = mem_ready ? S_F2 : S_F1;
      S_F2:    state_nx = S_E0;
      S_E0: begin
        if (op == OP_LD || op == OP_ST)                state_nx = S_E1;
        else if (op == OP_HALT || op[4:3] == 2'b11)    state_nx = S_HALT;
        else                                           state_nx = S_F0;
      end
      S_E1: begin
        if (op == OP_LD)      state_nx = mem_ready ? S_E2 : S_E1;
        else if (op == OP_ST) state_nx = S_E2;
        else                  state_nx = S_F0;
      end
      S_E2:    state_nx = (op == OP_ST && !mem_ready) ? S_E2 : S_F0;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_RESET;
    endcase
  end

  // State register; the illegal flag latches on an undefined opcode until reset
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_RESET;
      illegal_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_E0 && op[4:3] == 2'b11) illegal_q <= 1'b1;
    end
  end

  // Output decode from state and ir_out; ir_out changes at the F2->E0 edge,
  // so E0 strobes cannot be precomputed a cycle early.
  always_comb begin
    ir_en = 1'b0; pc_increment = 1'b0; pc_in_alu = 1'b0; pc_in_rf_a = 1'b0;
    ma_in_pc = 1'b0; ma_in_alu = 1'b0; md_in_memory = 1'b0; md_in_rf_b = 1'b0;
    alu_a_in_rf = 1'b0; alu_a_in_pc = 1'b0; alu_b_in_rf = 1'b0;
    alu_b_in_constant = 1'b0; lo_en = 1'b0; hi_en = 1'b0; rf_in_alu = 1'b0;
    rf_in_hi = 1'b0; rf_in_lo = 1'b0; rf_in_md = 1'b0;
    rf_a_addr = 4'd0; rf_b_addr = 4'd0; rf_z_addr = 4'd0;
    alu_select = 12'd0; constant_c = 32'd0;
    mem_read = 1'b0; mem_write = 1'b0;
    halted = 1'b0; illegal = 1'b0;
    case (state)
      S_F0: ma_in_pc = 1'b1;
      S_F1: begin
        mem_read     = 1'b1;
        md_in_memory = mem_ready;
        pc_increment = mem_ready;
      end
      S_F2: ir_en = 1'b1;
      S_E0: begin
        case (op)
          5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07: begin
            rf_a_addr   = rb;
            rf_b_addr   = rc;
            alu_a_in_rf = 1'b1;
            alu_b_in_rf = 1'b1;
            alu_select  = ALU_ADD >> op[2:0];
            rf_in_alu   = 1'b1;
            rf_z_addr   = ra;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            rf_a_addr         = rb;
            alu_a_in_rf       = 1'b1;
            alu_b_in_constant = 1'b1;
            constant_c        = c_ext;
            alu_select        = (op == OP_ADDI) ? ALU_ADD :
                                (op == OP_ANDI) ? ALU_AND : ALU_OR;
            rf_in_alu         = 1'b1;
            rf_z_addr         = ra;
          end
          OP_LD, OP_ST: begin
            // effective address rb + C into MA
            rf_a_addr         = rb;
            alu_a_in_rf       = 1'b1;
            alu_b_in_constant = 1'b1;
            constant_c        = c_ext;
            alu_select        = ALU_ADD;
            ma_in_alu         = 1'b1;
          end
          OP_MUL, OP_DIV: begin
            rf_a_addr   = ra;
            rf_b_addr   = rb;
            alu_a_in_rf = 1'b1;
            alu_b_in_rf = 1'b1;
            alu_select  = (op == OP_MUL) ? ALU_MUL : ALU_DIV;
            lo_en       = 1'b1;
            hi_en       = 1'b1;
          end
          OP_NEG, OP_NOT: begin
            rf_a_addr   = rb;
            alu_a_in_rf = 1'b1;
            alu_select  = (op == OP_NEG) ? ALU_NEG : ALU_NOT;
            rf_in_alu   = 1'b1;
            rf_z_addr   = ra;
          end
          OP_MFHI: begin
            rf_in_hi  = 1'b1;
            rf_z_addr = ra;
          end
          OP_MFLO: begin
            rf_in_lo  = 1'b1;
            rf_z_addr = ra;
          end
          OP_JR: begin
            rf_a_addr  = ra;
            pc_in_rf_a = 1'b1;
          end
          OP_JAL: begin
            // PC <- ra and r15 <- PC + 0 in one cycle; both read old values
            rf_a_addr         = ra;
            pc_in_rf_a        = 1'b1;
            alu_a_in_pc       = 1'b1;
            alu_b_in_constant = 1'b1;
            alu_select        = ALU_ADD;
            rf_in_alu         = 1'b1;
            rf_z_addr         = 4'd15;
          end
          OP_BR: begin
            // PC already points past the branch, so the offset is relative to it
            alu_a_in_pc       = 1'b1;
            alu_b_in_constant = 1'b1;
            constant_c        = c_ext;
            alu_select        = ALU_ADD;
            pc_in_alu         = 1'b1;
          end
          default: ;
        endcase
      end
      S_E1: begin
        if (op == OP_LD) begin
          mem_read     = 1'b1;
          md_in_memory = mem_ready;
        end else if (op == OP_ST) begin
          rf_b_addr  = ra;
          md_in_rf_b = 1'b1;
        end
      end
      S_E2: begin
        if (op == OP_LD) begin
          rf_in_md  = 1'b1;
          rf_z_addr = ra;
        end else if (op == OP_ST) begin
          mem_write = 1'b1;
        end
      end
      S_HALT: begin
        halted  = 1'b1;
        illegal = illegal_q;
      end
      default: ;
    endcase
  end

endmodule
